// File: rtl/uart_xmtr_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the transmit state encoding and the default frame width.
package uart_xmtr_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_STOP2 = 3'd4,
        TX_XXX   = 3'd7
    } uart_tx_e;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/uart_xmtr_edge_to_pulse.sv
// Registered edge detector: one-clk pulse the cycle after an edge is seen.
// PULSE_TYPE selects "redge", "fedge" or "both".
module uart_xmtr_edge_to_pulse #(
    parameter PULSE_TYPE = "redge"
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;
    logic hit;

    generate
        if (PULSE_TYPE == "fedge") begin : g_fedge
            assign hit = ~sig_i & prev_q;
        end else if (PULSE_TYPE == "both") begin : g_both
            assign hit = sig_i ^ prev_q;
        end else begin : g_redge
            assign hit = sig_i & ~prev_q;
        end
    endgenerate

    // Track the input during reset so release never fakes an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= sig_i;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            pulse_q <= hit;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/uart_xmtr.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, stop bit(s), paced by baud_i.
// Define UART_XMTR_TWO_STOP_EN for two stop-bit periods (TX_STOP2).
module uart_xmtr
    import uart_xmtr_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  baud_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_load_i,
    input  logic                  tx_ovf_clr_i,
    output logic                  serial_o,
    output logic                  tx_rdy_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o,
    output logic                  tx_ovf_o
);

    localparam int CW = cnt_width(DATA_WIDTH);

    logic                  baud_redg;
    uart_tx_e              state_q, state_n;
    logic [DATA_WIDTH-1:0] hold_q, hold_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic                  full_q, full_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  serial_q, serial_n;
    logic                  done_q, done_n;
    logic                  ovf_q, ovf_n;
    logic                  start_frame;

    uart_xmtr_edge_to_pulse #(
        .PULSE_TYPE("redge")
    ) u_baud_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (baud_i),
        .pulse_o(baud_redg)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= TX_IDLE;
            hold_q   <= '0;
            shift_q  <= '0;
            full_q   <= 1'b0;
            cnt_q    <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            hold_q   <= hold_n;
            shift_q  <= shift_n;
            full_q   <= full_n;
            cnt_q    <= cnt_n;
            serial_q <= serial_n;
            done_q   <= done_n;
            ovf_q    <= ovf_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        hold_n      = hold_q;
        shift_n     = shift_q;
        full_n      = full_q;
        cnt_n       = cnt_q;
        serial_n    = serial_q;
        done_n      = 1'b0;
        ovf_n       = ovf_q;
        start_frame = 1'b0;

        if (tx_load_i && !full_q) begin
            hold_n = tx_data_i;
            full_n = 1'b1;
        end

        // A fresh overflow beats a clear in the same cycle
        if (tx_load_i && full_q) begin
            ovf_n = 1'b1;
        end else if (tx_ovf_clr_i) begin
            ovf_n = 1'b0;
        end

        if (baud_redg) begin
            case (state_q)
                TX_IDLE: begin
                    serial_n    = 1'b1;
                    start_frame = full_q;
                end
                TX_START: begin
                    state_n  = TX_DATA;
                    serial_n = shift_q[0];
                    shift_n  = shift_q >> 1;
                    cnt_n    = CW'(1);
                end
                TX_DATA: begin
                    if (cnt_q < CW'(DATA_WIDTH)) begin
                        serial_n = shift_q[0];
                        shift_n  = shift_q >> 1;
                        cnt_n    = cnt_q + CW'(1);
                    end else begin
                        state_n  = TX_STOP;
                        serial_n = 1'b1;
                    end
                end
`ifdef UART_XMTR_TWO_STOP_EN
                TX_STOP: begin
                    state_n = TX_STOP2;
                end
                TX_STOP2: begin
                    done_n      = 1'b1;
                    state_n     = TX_IDLE;
                    start_frame = full_q;
                end
`else
                TX_STOP: begin
                    done_n      = 1'b1;
                    state_n     = TX_IDLE;
                    start_frame = full_q;
                end
`endif
                default: begin
                    state_n  = TX_XXX;
                    serial_n = 1'bx;
                end
            endcase
        end

        // Hold-to-shift transfer; a pending word chains with no idle gap
        if (start_frame) begin
            state_n  = TX_START;
            shift_n  = hold_q;
            full_n   = 1'b0;
            serial_n = 1'b0;
        end
    end

    assign serial_o  = serial_q;
    assign tx_rdy_o  = ~full_q;
    assign tx_busy_o = (state_q != TX_IDLE);
    assign tx_done_o = done_q;
    assign tx_ovf_o  = ovf_q;

endmodule

// File: tb/tb_uart_xmtr.sv
// Directed bench for uart_xmtr with a mid-bit sampling receiver model.
// Stop-bit count follows UART_XMTR_TWO_STOP_EN.
module tb_uart_xmtr;

`ifdef UART_XMTR_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif
    localparam int BAUD_CLKS = 16;
    localparam int FRAME     = 1 + 8 + STOPS;
    localparam int CLK_T     = 10;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       baud    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       serial_o;
    logic       tx_rdy_o;
    logic       tx_busy_o;
    logic       tx_done_o;
    logic       tx_ovf_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  d;
        logic        stop_ok;
        logic [63:0] t;
    } frame_t;

    frame_t q[$];
    int     rd = 0;

    logic cnt_clr  = 1'b0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    uart_xmtr dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .baud_i      (baud),
        .tx_data_i   (tx_data),
        .tx_load_i   (tx_load),
        .tx_ovf_clr_i(ovf_clr),
        .serial_o    (serial_o),
        .tx_rdy_o    (tx_rdy_o),
        .tx_busy_o   (tx_busy_o),
        .tx_done_o   (tx_done_o),
        .tx_ovf_o    (tx_ovf_o)
    );

    always #(CLK_T / 2) clk = ~clk;

    always begin
        repeat (BAUD_CLKS / 2) @(posedge clk);
        #1 baud = ~baud;
    end

    always @(negedge clk) begin
        if (cnt_clr) begin
            done_cnt <= 0;
            busy_cnt <= 0;
        end else begin
            if (tx_done_o === 1'b1) done_cnt <= done_cnt + 1;
            if (tx_busy_o === 1'b1) busy_cnt <= busy_cnt + 1;
        end
    end

    // Receiver model: samples on the falling baud edge (mid-bit)
    always begin : rx_mon
        frame_t      f;
        logic [63:0] t0;
        @(negedge baud);
        if (rst === 1'b0 && serial_o === 1'b0) begin
            t0        = $time;
            f.d       = 8'h00;
            f.stop_ok = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge baud);
                f.d[i] = serial_o;
            end
            for (int i = 0; i < STOPS; i++) begin
                @(negedge baud);
                if (serial_o !== 1'b1) f.stop_ok = 1'b0;
            end
            f.t = t0;
            q.push_back(f);
        end
    end

    initial begin
        #(200000);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_cnt();
        @(posedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (tx_rdy_o !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_rdy_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_rdy_wait got=%b want=1", tag, tx_rdy_o);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int budget = (n * FRAME + 3) * BAUD_CLKS + 100;
        int k = 0;
        while (q.size() < rd + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (q.size() < rd + n) begin
            bad++;
            $display("FAIL %s_frames got=%0d want=%0d", tag, q.size() - rd, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (serial_o !== 1'b1) begin
            bad++; $display("FAIL rst_serial got=%b want=1", serial_o);
        end
        total++;
        if (tx_rdy_o !== 1'b1) begin
            bad++; $display("FAIL rst_rdy got=%b want=1", tx_rdy_o);
        end
        total++;
        if (tx_busy_o !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b want=0", tx_busy_o);
        end
        total++;
        if (tx_done_o !== 1'b0) begin
            bad++; $display("FAIL rst_done got=%b want=0", tx_done_o);
        end
        total++;
        if (tx_ovf_o !== 1'b0) begin
            bad++; $display("FAIL rst_ovf got=%b want=0", tx_ovf_o);
        end
        rst = 1'b0;
        repeat (3 * BAUD_CLKS) @(negedge clk);
        total++;
        if (serial_o !== 1'b1 || tx_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle got=%b/%b want=1/0", serial_o, tx_busy_o);
        end
    endtask

    task automatic test_single();
        clr_cnt();
        rd = q.size();
        load(8'hA5);
        total++;
        if (tx_rdy_o !== 1'b0) begin
            bad++; $display("FAIL single_rdy got=%b want=0", tx_rdy_o);
        end
        wait_frames(1, "single");
        repeat (BAUD_CLKS) @(negedge clk);
        if (q.size() > rd) begin
            total++;
            if (q[rd].d !== 8'hA5) begin
                bad++; $display("FAIL single_data got=%h want=a5", q[rd].d);
            end
            total++;
            if (q[rd].stop_ok !== 1'b1) begin
                bad++; $display("FAIL single_stop got=%b want=1", q[rd].stop_ok);
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++; $display("FAIL single_done got=%0d want=1", done_cnt);
        end
        total++;
        if (busy_cnt !== FRAME * BAUD_CLKS) begin
            bad++;
            $display("FAIL single_len got=%0d want=%0d", busy_cnt, FRAME * BAUD_CLKS);
        end
        total++;
        if (tx_busy_o !== 1'b0 || serial_o !== 1'b1) begin
            bad++;
            $display("FAIL single_idle got=%b/%b want=0/1", tx_busy_o, serial_o);
        end
        rd = q.size();
    endtask

    task automatic test_back_to_back();
        clr_cnt();
        rd = q.size();
        load(8'h3C);
        wait_rdy("b2b");
        total++;
        if (tx_busy_o !== 1'b1) begin
            bad++; $display("FAIL b2b_busy got=%b want=1", tx_busy_o);
        end
        load(8'hFF);
        wait_frames(2, "b2b");
        repeat (BAUD_CLKS) @(negedge clk);
        if (q.size() >= rd + 2) begin
            total++;
            if (q[rd].d !== 8'h3C || q[rd+1].d !== 8'hFF) begin
                bad++;
                $display("FAIL b2b_data got=%h,%h want=3c,ff", q[rd].d, q[rd+1].d);
            end
            total++;
            if (q[rd].stop_ok !== 1'b1 || q[rd+1].stop_ok !== 1'b1) begin
                bad++;
                $display("FAIL b2b_stop got=%b%b want=11", q[rd].stop_ok, q[rd+1].stop_ok);
            end
            total++;
            if (q[rd+1].t - q[rd].t !== 64'(FRAME * BAUD_CLKS * CLK_T)) begin
                bad++;
                $display("FAIL b2b_gap got=%0d want=%0d",
                         q[rd+1].t - q[rd].t, FRAME * BAUD_CLKS * CLK_T);
            end
        end
        total++;
        if (done_cnt !== 2) begin
            bad++; $display("FAIL b2b_done got=%0d want=2", done_cnt);
        end
        rd = q.size();
    endtask

    task automatic test_overflow();
        clr_cnt();
        rd = q.size();
        load(8'h5A);
        total++;
        if (tx_rdy_o !== 1'b0) begin
            bad++; $display("FAIL ovf_rdy got=%b want=0", tx_rdy_o);
        end
        tx_data = 8'hC3;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        total++;
        if (tx_ovf_o !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%b want=1", tx_ovf_o);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total++;
        if (tx_ovf_o !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got=%b want=0", tx_ovf_o);
        end
        wait_rdy("ovf");
        load(8'h96);
        total++;
        if (tx_rdy_o !== 1'b0) begin
            bad++; $display("FAIL ovf_full got=%b want=0", tx_rdy_o);
        end
        tx_data = 8'h0F;
        tx_load = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        ovf_clr = 1'b0;
        total++;
        if (tx_ovf_o !== 1'b1) begin
            bad++; $display("FAIL ovf_set_wins got=%b want=1", tx_ovf_o);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total++;
        if (tx_ovf_o !== 1'b0) begin
            bad++; $display("FAIL ovf_clear2 got=%b want=0", tx_ovf_o);
        end
        wait_frames(2, "ovf");
        repeat (3 * BAUD_CLKS) @(negedge clk);
        if (q.size() >= rd + 2) begin
            total++;
            if (q[rd].d !== 8'h5A || q[rd+1].d !== 8'h96) begin
                bad++;
                $display("FAIL ovf_hold got=%h,%h want=5a,96", q[rd].d, q[rd+1].d);
            end
        end
        total++;
        if (q.size() !== rd + 2) begin
            bad++; $display("FAIL ovf_extra got=%0d want=2", q.size() - rd);
        end
        rd = q.size();
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        int lows = 0;
        clr_cnt();
        load(8'h81);
        while (serial_o !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (serial_o !== 1'b0) begin
            bad++; $display("FAIL mid_start got=%b want=0", serial_o);
        end
        load(8'h7E);
        repeat (5 * BAUD_CLKS + 8 - 2) @(negedge clk);
        total++;
        if (serial_o !== 1'b0 || tx_rdy_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_bit4 got=%b/%b want=0/0", serial_o, tx_rdy_o);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (serial_o !== 1'b1) begin
            bad++; $display("FAIL mid_rst_serial got=%b want=1", serial_o);
        end
        total++;
        if (tx_rdy_o !== 1'b1 || tx_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_flags got=%b/%b want=1/0", tx_rdy_o, tx_busy_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * BAUD_CLKS) begin
            @(negedge clk);
            if (serial_o !== 1'b1 || tx_busy_o !== 1'b0) lows++;
        end
        total++;
        if (lows !== 0) begin
            bad++; $display("FAIL mid_no_frame got=%0d want=0", lows);
        end
        total++;
        if (done_cnt !== 0) begin
            bad++; $display("FAIL mid_no_done got=%0d want=0", done_cnt);
        end
        rd = q.size();
    endtask

    task automatic test_loopback();
        logic [7:0] w[4];
        w[0] = 8'h00;
        w[1] = 8'h55;
        w[2] = 8'hAA;
        w[3] = 8'hFF;
        clr_cnt();
        rd = q.size();
        for (int i = 0; i < 4; i++) begin
            wait_rdy("loop");
            load(w[i]);
        end
        wait_frames(4, "loop");
        repeat (BAUD_CLKS) @(negedge clk);
        if (q.size() >= rd + 4) begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q[rd+i].d !== w[i] || q[rd+i].stop_ok !== 1'b1) begin
                    bad++;
                    $display("FAIL loop_word%0d got=%h/%b want=%h/1",
                             i, q[rd+i].d, q[rd+i].stop_ok, w[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (q[rd+i].t - q[rd+i-1].t !== 64'(FRAME * BAUD_CLKS * CLK_T)) begin
                    bad++;
                    $display("FAIL loop_gap%0d got=%0d want=%0d", i,
                             q[rd+i].t - q[rd+i-1].t, FRAME * BAUD_CLKS * CLK_T);
                end
            end
        end
        total++;
        if (done_cnt !== 4) begin
            bad++; $display("FAIL loop_done got=%0d want=4", done_cnt);
        end
        rd = q.size();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
